data_sram_resp: RTL and testbench

//   Responder end of the LSU data_sram request interface: a synchronous, byte-writable 64-bit

---
 rtl/data_sram_resp_pkg.sv | 40 ++++
 rtl/data_sram_resp_if.sv | 38 +++
 rtl/data_sram_resp_load_align.sv | 43 ++++
 rtl/data_sram_resp.sv | 135 +++++++++++++
 tb/tb_data_sram_resp.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/data_sram_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_resp_pkg
//   Definitions shared by the LSU and the data SRAM responder:
//     - one-hot access-size encodings (same encoding as the lsu_op size field)
//     - small helpers for size legality and natural-alignment checks
//   No ports; imported with "import data_sram_resp_pkg::*;".
// -----------------------------------------------------------------------------
package data_sram_resp_pkg;

  typedef logic [3:0] lsu_size_t;

  // One-hot {dword, word, half, byte}
  localparam lsu_size_t SIZE_B = 4'b0001;
  localparam lsu_size_t SIZE_H = 4'b0010;
  localparam lsu_size_t SIZE_W = 4'b0100;
  localparam lsu_size_t SIZE_D = 4'b1000;

  // Width of the byte offset within a 64-bit word
  localparam int unsigned OFF_W = 3;

  // A size field is usable only if exactly one of the four encodings is set.
  function automatic logic size_is_legal(input lsu_size_t size);
    return (size == SIZE_B) || (size == SIZE_H) ||
           (size == SIZE_W) || (size == SIZE_D);
  endfunction

  // Natural alignment: the access must not straddle its own size boundary.
  // Bytes can never be misaligned; an illegal size reports no misalignment
  // (it is flagged separately).
  function automatic logic is_misaligned(input lsu_size_t size,
                                         input logic [OFF_W-1:0] off);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_H) mis = off[0];
    if (size == SIZE_W) mis = (off[1:0] != 2'b00);
    if (size == SIZE_D) mis = (off != 3'b000);
    return mis;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// -----------------------------------------------------------------------------
// data_sram_resp_if
//   Request/response bundle between the LSU issue stage (master) and the data
//   SRAM responder (slave).
//   Request  (master -> slave): data_sram_en, data_sram_we[7:0],
//            data_sram_addr[63:0], data_sram_wdata[63:0], lsu_size[3:0],
//            lsu_unsigned
//   Response (slave -> master): data_sram_rdata[63:0], load_data[63:0],
//            resp_valid, resp_err
// -----------------------------------------------------------------------------
interface data_sram_resp_if;
  import data_sram_resp_pkg::*;

  logic        data_sram_en;
  logic [7:0]  data_sram_we;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  lsu_size_t   lsu_size;
  logic        lsu_unsigned;

  logic [63:0] data_sram_rdata;
  logic [63:0] load_data;
  logic        resp_valid;
  logic        resp_err;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           lsu_size, lsu_unsigned,
    input  data_sram_rdata, load_data, resp_valid, resp_err
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           lsu_size, lsu_unsigned,
    output data_sram_rdata, load_data, resp_valid, resp_err
  );

endinterface

// File: rtl/data_sram_resp_load_align.sv
// -----------------------------------------------------------------------------
// data_sram_resp_load_align
//   Combinational load formatter: picks the addressed lane out of the raw
//   64-bit word and sign- or zero-extends it to 64 bits.
//   Ports:
//     rdata        in  64  raw word read from the array
//     off          in  3   byte offset of the access within the word
//     size         in  4   one-hot access size
//     lsu_unsigned in  1   1 = zero-extend, 0 = sign-extend
//     load_data    out 64  formatted result (0 for an illegal size)
// -----------------------------------------------------------------------------
module data_sram_resp_load_align
  import data_sram_resp_pkg::*;
(
  input  logic [63:0]      rdata,
  input  logic [OFF_W-1:0] off,
  input  lsu_size_t        size,
  input  logic             lsu_unsigned,
  output logic [63:0]      load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Lane selects: byte uses the full offset, half the upper two bits,
  // word only bit 2. Alignment was checked at request time.
  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[2:1], 4'b0000} +: 16];
  assign word_sel = off[2] ? rdata[63:32] : rdata[31:0];

  always_comb begin
    load_data = 64'd0;
    case (size)
      SIZE_B: load_data = {{56{~lsu_unsigned & byte_sel[7]}},  byte_sel};
      SIZE_H: load_data = {{48{~lsu_unsigned & half_sel[15]}}, half_sel};
      SIZE_W: load_data = {{32{~lsu_unsigned & word_sel[31]}}, word_sel};
      SIZE_D: load_data = rdata;
      default: load_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//   Responder end of the LSU data_sram interface: single-port, byte-writable
//   64-bit data memory with a one-cycle response. Stores apply byte enables;
//   loads return the raw word plus an aligned, extended result. Misaligned,
//   out-of-range and bad-size requests are answered with resp_err and never
//   touch the array.
//   Parameters:
//     DEPTH      number of 64-bit words (power of two, >= 2)
//     BASE_ADDR  byte address of word 0 (8-byte aligned)
//   Ports:
//     clk    in  clock, all state on the rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    data_sram_resp_if.slave (request in, response out)
// -----------------------------------------------------------------------------
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  data_sram_resp_if.slave  bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [60:0] BASE_WORD = BASE_ADDR[63:3];

  // ---------------------------------------------------------------------------
  // Request decode (request cycle)
  // ---------------------------------------------------------------------------
  logic [60:0]      req_word;
  logic [60:0]      word_off;
  logic [AW-1:0]    index;
  logic [OFF_W-1:0] req_off;
  logic             out_of_range;
  logic             bad_size;
  logic             misaligned;
  logic             req_err;
  logic             is_store;
  logic             accept_store;
  logic             accept_load;

  // BASE_ADDR is 8-byte aligned, so range checks work on word addresses.
  assign req_word     = bus.data_sram_addr[63:3];
  assign req_off      = bus.data_sram_addr[2:0];
  assign word_off     = req_word - BASE_WORD;
  assign index        = word_off[AW-1:0];
  assign out_of_range = (req_word < BASE_WORD) || (word_off >= 61'(DEPTH));
  assign bad_size     = !size_is_legal(bus.lsu_size);
  assign misaligned   = is_misaligned(bus.lsu_size, req_off);
  assign req_err      = out_of_range | bad_size | misaligned;

  assign is_store     = |bus.data_sram_we;
  assign accept_store = bus.data_sram_en &  is_store & ~req_err;
  assign accept_load  = bus.data_sram_en & ~is_store & ~req_err;

  // ---------------------------------------------------------------------------
  // Storage: one 8-bit array per byte lane so each lane has its own write
  // enable. Array and read register carry no reset so they map onto block RAM.
  // ---------------------------------------------------------------------------
  logic [63:0] rd_word;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_byte;

      always_ff @(posedge clk) begin
        if (accept_store && bus.data_sram_we[gi]) begin
          lane_mem[index] <= bus.data_sram_wdata[8*gi +: 8];
        end
        if (accept_load) begin
          rd_byte <= lane_mem[index];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response pipeline
  //   rdata_ok_reg marks whether rd_word holds a good load result; it is
  //   cleared by reset and by an errored load so the visible data reads 0
  //   without resetting the RAM output register. Stores leave it and the
  //   formatting fields untouched, so load outputs hold across store responses.
  // ---------------------------------------------------------------------------
  logic             resp_valid_reg;
  logic             resp_err_reg;
  logic             rdata_ok_reg;
  logic [OFF_W-1:0] fmt_off_reg;
  lsu_size_t        fmt_size_reg;
  logic             fmt_unsigned_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg   <= 1'b0;
      resp_err_reg     <= 1'b0;
      rdata_ok_reg     <= 1'b0;
      fmt_off_reg      <= '0;
      fmt_size_reg     <= '0;
      fmt_unsigned_reg <= 1'b0;
    end else begin
      resp_valid_reg <= bus.data_sram_en;
      resp_err_reg   <= bus.data_sram_en & req_err;
      if (bus.data_sram_en && !is_store) begin
        rdata_ok_reg     <= ~req_err;
        fmt_off_reg      <= req_off;
        fmt_size_reg     <= bus.lsu_size;
        fmt_unsigned_reg <= bus.lsu_unsigned;
      end
    end
  end

  logic [63:0] rdata_vis;
  logic [63:0] load_fmt;

  assign rdata_vis = rdata_ok_reg ? rd_word : 64'd0;

  data_sram_resp_load_align u_load_align (
    .rdata        (rdata_vis),
    .off          (fmt_off_reg),
    .size         (fmt_size_reg),
    .lsu_unsigned (fmt_unsigned_reg),
    .load_data    (load_fmt)
  );

  assign bus.data_sram_rdata = rdata_vis;
  assign bus.load_data       = load_fmt;
  assign bus.resp_valid      = resp_valid_reg;
  assign bus.resp_err        = resp_err_reg;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//   Directed bench for data_sram_resp. Requests are driven just after a
//   rising edge; responses are sampled 1 time unit after the edge that
//   captured them. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;
  import data_sram_resp_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int unsigned DEPTH = 512;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_sram_resp_if bus ();

  data_sram_resp #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, let the next edge capture it, then sample.
  task automatic issue(input logic [7:0] we, input logic [63:0] addr,
                       input logic [63:0] wdata, input lsu_size_t size,
                       input logic uns);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    bus.lsu_size        = size;
    bus.lsu_unsigned    = uns;
    @(posedge clk);
    #1;
    bus.data_sram_en    = 1'b0;
    $display("txn we=%h addr=%h size=%b uns=%0d -> valid=%0d err=%0d load_data=%h",
             we, addr, size, uns, bus.resp_valid, bus.resp_err, bus.load_data);
  endtask

  task automatic idle(input int n);
    bus.data_sram_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n               = 1'b0;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 8'h00;
    bus.data_sram_addr  = 64'd0;
    bus.data_sram_wdata = 64'd0;
    bus.lsu_size        = SIZE_D;
    bus.lsu_unsigned    = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", bus.data_sram_rdata, 64'd0);
    check("rst_load_data", bus.load_data, 64'd0);
    check("rst_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_err", 64'(bus.resp_err), 64'd0);
    rst_n = 1'b1;
    idle(3);
    check("idle_valid", 64'(bus.resp_valid), 64'd0);

    // Dword store then load at BASE
    issue(8'hFF, BASE, 64'h0123_4567_89AB_CDEF, SIZE_D, 1'b0);
    check("st_d_valid", 64'(bus.resp_valid), 64'd1);
    check("st_d_err", 64'(bus.resp_err), 64'd0);
    issue(8'h00, BASE, 64'd0, SIZE_D, 1'b0);
    check("ld_d_valid", 64'(bus.resp_valid), 64'd1);
    check("ld_d_err", 64'(bus.resp_err), 64'd0);
    check("ld_d_data", bus.load_data, 64'h0123_4567_89AB_CDEF);
    check("ld_d_rdata", bus.data_sram_rdata, 64'h0123_4567_89AB_CDEF);
    idle(1);
    check("pulse_drop", 64'(bus.resp_valid), 64'd0);

    // Byte store at BASE+5; load outputs hold across the store response
    issue(8'h20, BASE + 64'd5, {8{8'h80}}, SIZE_B, 1'b0);
    check("st_b_err", 64'(bus.resp_err), 64'd0);
    check("st_b_hold", bus.load_data, 64'h0123_4567_89AB_CDEF);
    issue(8'h00, BASE + 64'd5, 64'd0, SIZE_B, 1'b1);
    check("ld_bu", bus.load_data, 64'h0000_0000_0000_0080);
    issue(8'h00, BASE + 64'd5, 64'd0, SIZE_B, 1'b0);
    check("ld_bs", bus.load_data, 64'hFFFF_FFFF_FFFF_FF80);
    issue(8'h00, BASE, 64'd0, SIZE_D, 1'b0);
    check("ld_b_others", bus.load_data, 64'h0123_8067_89AB_CDEF);

    // Misaligned accesses
    issue(8'h00, BASE + 64'd3, 64'd0, SIZE_H, 1'b0);
    check("mis_h_err", 64'(bus.resp_err), 64'd1);
    check("mis_h_valid", 64'(bus.resp_valid), 64'd1);
    check("mis_h_data", bus.load_data, 64'd0);
    issue(8'h3C, BASE + 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, SIZE_W, 1'b0);
    check("mis_w_err", 64'(bus.resp_err), 64'd1);
    issue(8'h00, BASE, 64'd0, SIZE_D, 1'b0);
    check("mis_w_nowrite", bus.load_data, 64'h0123_8067_89AB_CDEF);

    // Range and size errors
    issue(8'h00, BASE + 64'(8 * DEPTH), 64'd0, SIZE_D, 1'b0);
    check("oor_high", 64'(bus.resp_err), 64'd1);
    issue(8'h00, BASE - 64'd8, 64'd0, SIZE_D, 1'b0);
    check("oor_low", 64'(bus.resp_err), 64'd1);
    issue(8'h00, BASE, 64'd0, 4'b0011, 1'b0);
    check("bad_size", 64'(bus.resp_err), 64'd1);

    // Last word in range
    issue(8'hFF, BASE + 64'(8 * (DEPTH - 1)), 64'hA5A5_0000_1111_2222, SIZE_D, 1'b0);
    check("last_st_err", 64'(bus.resp_err), 64'd0);
    issue(8'h00, BASE + 64'(8 * (DEPTH - 1)), 64'd0, SIZE_D, 1'b0);
    check("last_ld", bus.load_data, 64'hA5A5_0000_1111_2222);

    // Back-to-back store/load (read-after-write)
    issue(8'hF0, BASE + 64'd4, {2{32'hDEAD_BEEF}}, SIZE_W, 1'b0);
    issue(8'h00, BASE + 64'd4, 64'd0, SIZE_W, 1'b0);
    check("raw_w", bus.load_data, 64'hFFFF_FFFF_DEAD_BEEF);
    issue(8'h00, BASE + 64'd6, 64'd0, SIZE_H, 1'b1);
    check("ld_hu", bus.load_data, 64'h0000_0000_0000_DEAD);
    issue(8'h00, BASE + 64'd4, 64'd0, SIZE_B, 1'b0);
    check("ld_bs_ef", bus.load_data, 64'hFFFF_FFFF_FFFF_FFEF);

    // Reset mid-operation: store at N, load presented at N+1 with rst_n low
    issue(8'h0F, BASE + 64'd8, 64'h0000_0000_1234_5678, SIZE_W, 1'b0);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_we    = 8'h00;
    bus.data_sram_addr  = BASE + 64'd8;
    bus.lsu_size        = SIZE_W;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.data_sram_en = 1'b0;
    check("rst_mid_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_mid_data", bus.load_data, 64'd0);
    rst_n = 1'b1;
    idle(2);
    check("rst_rel_valid", 64'(bus.resp_valid), 64'd0);

    // Memory survives reset
    issue(8'h00, BASE, 64'd0, SIZE_D, 1'b0);
    check("post_rst_valid", 64'(bus.resp_valid), 64'd1);
    check("post_rst_data", bus.load_data, 64'hDEAD_BEEF_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
